// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
// Optional feature macro used across this slice: CLA_OVF_EN (signed-overflow output).
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } cla_state_e;

  function automatic int unsigned cla_ng(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int unsigned cla_idx_w(input int unsigned ng);
    return (ng <= 1) ? 1 : $clog2(ng);
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// ovf_o exists only when CLA_OVF_EN is defined.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
`ifdef CLA_OVF_EN
  logic             ovf_o;
`endif

  modport master (
    output in_valid_i, a_i, b_i, c_i, out_ready_i,
`ifdef CLA_OVF_EN
    input  ovf_o,
`endif
    input  in_ready_o, out_valid_o, s_o, c_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, c_i, out_ready_i,
`ifdef CLA_OVF_EN
    output ovf_o,
`endif
    output in_ready_o, out_valid_o, s_o, c_o
  );

endinterface

// File: rtl/cla_seq_adder_group_unit.sv
// Combinational GROUP-bit lookahead slice: every internal carry is expanded from the
// slice carry-in instead of rippling. c_msb_o exists only with CLA_OVF_EN.
module cla_group_unit #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
`ifdef CLA_OVF_EN
  output logic             c_msb_o,
`endif
  output logic [GROUP-1:0] s_o,
  output logic             c_o
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP:0]   w_carry;
  logic             w_acc;
  logic             w_pp;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // c[j+1] = g[j] | p[j]g[j-1] | ... | p[j]..p[0]c_in, built as a flat sum of products.
  always_comb begin
    w_carry    = '0;
    w_acc      = 1'b0;
    w_pp       = 1'b0;
    w_carry[0] = c_i;
    for (int j = 0; j < int'(GROUP); j++) begin
      w_acc = w_g[j];
      w_pp  = w_p[j];
      for (int i = j - 1; i >= 0; i--) begin
        w_acc = w_acc | (w_pp & w_g[i]);
        w_pp  = w_pp & w_p[i];
      end
      w_acc        = w_acc | (w_pp & c_i);
      w_carry[j+1] = w_acc;
    end
  end

  assign s_o = w_p ^ w_carry[GROUP-1:0];
  assign c_o = w_carry[GROUP];
`ifdef CLA_OVF_EN
  assign c_msb_o = w_carry[GROUP-1];
`endif

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder resolving one GROUP-bit lookahead slice per clock, LSB slice first.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf_o.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic         clk_i,
  input  logic         rst_i,
  cla_seq_adder_if.slave bus
);

  localparam int unsigned NG    = cla_ng(WIDTH, GROUP);
  localparam int unsigned IDX_W = cla_idx_w(NG);

  if ((WIDTH % GROUP) != 0 || NG == 0) begin : g_param_check
    $error("cla_seq_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  cla_state_e       r_state;
  cla_state_e       w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [31:0]      w_base;
  logic [GROUP-1:0] w_a_slice;
  logic [GROUP-1:0] w_b_slice;
  logic [GROUP-1:0] w_sum_slice;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;

`ifdef CLA_OVF_EN
  logic             r_ovf;
  logic             w_c_msb;
`endif

  assign w_base    = 32'(r_idx) * GROUP;
  assign w_a_slice = r_a[w_base +: GROUP];
  assign w_b_slice = r_b[w_base +: GROUP];
  assign w_last    = (r_idx == IDX_W'(NG - 1));
  assign w_accept  = (r_state == StIdle) && bus.in_valid_i;

  cla_group_unit #(
    .GROUP (GROUP)
  ) u_group (
    .a_i     (w_a_slice),
    .b_i     (w_b_slice),
    .c_i     (r_carry),
`ifdef CLA_OVF_EN
    .c_msb_o (w_c_msb),
`endif
    .s_o     (w_sum_slice),
    .c_o     (w_cout)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.in_valid_i) w_state_d = StCalc;
      StCalc:  if (w_last) w_state_d = StDone;
      StDone:  if (bus.out_ready_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // The carry register doubles as c_o once the final slice has been written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a_i;
      r_b     <= bus.b_i;
      r_carry <= bus.c_i;
      r_idx   <= '0;
    end else if (r_state == StCalc) begin
      r_sum[w_base +: GROUP] <= w_sum_slice;
      r_carry                <= w_cout;
      r_idx                  <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

`ifdef CLA_OVF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (r_state == StCalc && w_last) begin
      r_ovf <= w_c_msb ^ w_cout;
    end
  end

  assign bus.ovf_o = r_ovf;
`endif

  assign bus.in_ready_o  = (r_state == StIdle);
  assign bus.out_valid_o = (r_state == StDone);
  assign bus.s_o         = r_sum;
  assign bus.c_o         = r_carry;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed corner cases plus random operands,
// checked against plain integer addition. Honours CLA_OVF_EN when defined.
module tb_cla_seq_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;
  localparam int          NG    = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus_if ();

  cla_seq_adder #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: widen, add, and read the signed overflow off the operand/result signs.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    exp_t        e;
    logic [WIDTH:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.s   = full[WIDTH-1:0];
    e.c   = full[WIDTH];
    e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  function automatic logic get_ovf();
`ifdef CLA_OVF_EN
    return bus_if.ovf_o;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compares whenever a result is presented and the consumer accepts it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && bus_if.out_valid_o && bus_if.out_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(bus_if.out_valid_o), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sum", 32'(bus_if.s_o), 32'(e.s));
          chk("carry_out", 32'(bus_if.c_o), 32'(e.c));
`ifdef CLA_OVF_EN
          chk("overflow", 32'(get_ovf()), 32'(e.ovf));
`endif
        end
      end
    end
  end

  // Called away from a clock edge; returns #1 after the handshake edge.
  task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input int bp);
    int             lat;
    logic [WIDTH-1:0] hold_s;
    logic           hold_c;
    chk("in_ready_idle", 32'(bus_if.in_ready_o), 32'(1));
    bus_if.a_i         = a;
    bus_if.b_i         = b;
    bus_if.c_i         = cin;
    bus_if.in_valid_i  = 1'b1;
    bus_if.out_ready_i = (bp == 0);
    sb_q.push_back(model(a, b, cin));
    @(posedge clk_i);
    #1;
    bus_if.in_valid_i = 1'b0;
    bus_if.a_i        = WIDTH'($urandom);
    bus_if.b_i        = WIDTH'($urandom);
    bus_if.c_i        = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i);
      #1;
      if (n == 2) bus_if.a_i = ~bus_if.a_i;
      if (bus_if.out_valid_o) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(NG));
    chk("in_ready_done", 32'(bus_if.in_ready_o), 32'(0));
    if (bp > 0) begin
      hold_s = bus_if.s_o;
      hold_c = bus_if.c_o;
      repeat (bp) begin
        @(posedge clk_i);
        #1;
        chk("bp_valid_held", 32'(bus_if.out_valid_o), 32'(1));
        chk("bp_sum_stable", 32'(bus_if.s_o), 32'(hold_s));
        chk("bp_carry_stable", 32'(bus_if.c_o), 32'(hold_c));
        chk("bp_in_ready_low", 32'(bus_if.in_ready_o), 32'(0));
      end
      bus_if.out_ready_i = 1'b1;
    end
    @(posedge clk_i);
    #1;
    chk("valid_dropped", 32'(bus_if.out_valid_o), 32'(0));
    chk("in_ready_after", 32'(bus_if.in_ready_o), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid_i  = 1'b0;
    bus_if.out_ready_i = 1'b0;
    bus_if.a_i         = '0;
    bus_if.b_i         = '0;
    bus_if.c_i         = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus_if.in_ready_o), 32'(1));
    chk("rst_out_valid", 32'(bus_if.out_valid_o), 32'(0));
    chk("rst_sum", 32'(bus_if.s_o), 32'(0));
    chk("rst_carry", 32'(bus_if.c_o), 32'(0));
`ifdef CLA_OVF_EN
    chk("rst_ovf", 32'(get_ovf()), 32'(0));
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    do_txn(16'h1234, 16'h4321, 1'b0, 0);
    do_txn(16'hFFFF, 16'h0001, 1'b0, 0);
    do_txn(16'h7FFF, 16'h0001, 1'b0, 0);
    do_txn(16'hFFFF, 16'hFFFF, 1'b1, 0);
    do_txn(16'h8000, 16'h8000, 1'b0, 0);
    do_txn(16'h0F0F, 16'h00F1, 1'b1, 5);

    // Reset two slices into a calculation; the pending expectation is discarded.
    chk("in_ready_pre_abort", 32'(bus_if.in_ready_o), 32'(1));
    bus_if.a_i         = 16'hAAAA;
    bus_if.b_i         = 16'h5555;
    bus_if.c_i         = 1'b0;
    bus_if.in_valid_i  = 1'b1;
    bus_if.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus_if.in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("abort_in_ready", 32'(bus_if.in_ready_o), 32'(1));
    chk("abort_out_valid", 32'(bus_if.out_valid_o), 32'(0));
    chk("abort_sum", 32'(bus_if.s_o), 32'(0));
    chk("abort_carry", 32'(bus_if.c_o), 32'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    do_txn(16'h0001, 16'h0001, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (t % 6 == 5) ? 2 : 0);
    end

    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
